game_ctrl: RTL and testbench

GAME_CTRL -- requirements
Module: game_ctrl

---
 rtl/game_ctrl.sv | 168 ++++++++++++++++
 tb/tb_game_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/game_ctrl.sv
// game_ctrl: button conditioning plus the IDLE/PLAY/DEAD/OVER round controller.
// The button is synchronised, debounced and reduced to a press event. The event
// is latched until the next game tick, and the FSM consumes it on that tick.
module game_ctrl #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int OVER_HOLD_TICKS = 60,
    parameter int SCORE_W         = 10
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               game_tick,
    input  logic               btn_raw,
    input  logic               hit_column,
    input  logic [SCORE_W-1:0] score,
    output logic               flap,
    output logic               round_rst,
    output logic               finished,
    output logic [1:0]         state,
    output logic [SCORE_W-1:0] high_score
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        DEAD = 2'd2,
        OVER = 2'd3
    } state_t;

    // Counter widths are sized so that the terminal count always fits.
    localparam int DEB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int HOLD_W = (OVER_HOLD_TICKS > 1) ? $clog2(OVER_HOLD_TICKS) : 1;
    localparam logic [DEB_W-1:0]  DEB_MAX  = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(OVER_HOLD_TICKS - 1);

    logic [1:0]         sync_reg;
    logic               btn_sync;
    logic [DEB_W-1:0]   deb_cnt_reg;
    logic               btn_stable_reg;
    logic               btn_prev_reg;
    logic               press_event;
    logic               pending_reg;
    logic               press_now;
    state_t             state_reg, state_next;
    logic [HOLD_W-1:0]  hold_reg, hold_next;
    logic [SCORE_W-1:0] hs_reg, hs_next;
    logic               finished_reg;

    assign btn_sync = sync_reg[1];

    // Two-flop synchroniser on the raw pushbutton.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_reg <= 2'b00;
        end else begin
            sync_reg <= {sync_reg[0], btn_raw};
        end
    end

    // Debounce: the synced level must differ from the accepted level for
    // DEBOUNCE_CYCLES consecutive clocks before it is accepted. Any return to
    // the accepted level restarts the count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            deb_cnt_reg    <= '0;
            btn_stable_reg <= 1'b0;
            btn_prev_reg   <= 1'b0;
        end else begin
            btn_prev_reg <= btn_stable_reg;
            if (btn_sync != btn_stable_reg) begin
                if (deb_cnt_reg == DEB_MAX) begin
                    btn_stable_reg <= ~btn_stable_reg;
                    deb_cnt_reg    <= '0;
                end else begin
                    deb_cnt_reg <= deb_cnt_reg + DEB_W'(1);
                end
            end else begin
                deb_cnt_reg <= '0;
            end
        end
    end

    // The press event is the single cycle following the stable level's 0->1 edge.
    assign press_event = btn_stable_reg & ~btn_prev_reg;
    // A press arriving in the same cycle as a tick counts for that tick.
    assign press_now   = pending_reg | press_event;

    // Every game tick consumes the pending press, whatever state uses it.
    // Several presses between ticks merge into one.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending_reg <= 1'b0;
        end else if (game_tick) begin
            pending_reg <= 1'b0;
        end else if (press_event) begin
            pending_reg <= 1'b1;
        end
    end

    // Next-state, hold counter, high-score update and the combinational tick pulses.
    always_comb begin
        state_next = state_reg;
        hold_next  = '0;
        hs_next    = hs_reg;
        flap       = 1'b0;
        round_rst  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (game_tick && press_now) begin
                    state_next = PLAY;
                    flap       = 1'b1;
                    round_rst  = 1'b1;
                end
            end
            PLAY: begin
                if (game_tick) begin
                    if (hit_column) begin
                        state_next = DEAD;
                        if (score > hs_reg) begin
                            hs_next = score;
                        end
                    end else if (press_now) begin
                        flap = 1'b1;
                    end
                end
            end
            DEAD: begin
                hold_next = hold_reg;
                if (game_tick) begin
                    if (hold_reg == HOLD_MAX) begin
                        state_next = OVER;
                        hold_next  = '0;
                    end else begin
                        hold_next = hold_reg + HOLD_W'(1);
                    end
                end
            end
            OVER: begin
                if (game_tick && press_now) begin
                    state_next = IDLE;
                    round_rst  = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State, hold counter, best score and the registered freeze flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= IDLE;
            hold_reg     <= '0;
            hs_reg       <= '0;
            finished_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            hold_reg     <= hold_next;
            hs_reg       <= hs_next;
            finished_reg <= (state_next == DEAD) || (state_next == OVER);
        end
    end

    assign state      = state_reg;
    assign finished   = finished_reg;
    assign high_score = hs_reg;

endmodule

// File: tb/tb_game_ctrl.sv
// tb_game_ctrl: directed sequence that walks the controller through each state.
// Every tick pops one expected record from the scoreboard and checks the
// tick-cycle pulses, then the state registered after that tick.
module tb_game_ctrl;

    localparam int SW = 10;

    logic          clk;
    logic          reset_n;
    logic          game_tick;
    logic          btn_raw;
    logic          hit_column;
    logic [SW-1:0] score;
    logic          flap;
    logic          round_rst;
    logic          finished;
    logic [1:0]    state;
    logic [SW-1:0] high_score;

    typedef struct {
        string         tag;
        logic          flap;
        logic          rrst;
        logic [1:0]    st;
        logic          fin;
        logic [SW-1:0] hs;
    } exp_t;

    exp_t sb[$];
    int   n_total;
    int   n_pass;

    game_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .OVER_HOLD_TICKS(3),
        .SCORE_W(SW)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .game_tick(game_tick),
        .btn_raw(btn_raw),
        .hit_column(hit_column),
        .score(score),
        .flap(flap),
        .round_rst(round_rst),
        .finished(finished),
        .state(state),
        .high_score(high_score)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_total = n_total + 1;
        assert (obs === expv) n_pass = n_pass + 1;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    endtask

    task automatic expect_tick(input string tag, input logic f, input logic r,
                               input logic [1:0] s, input logic fn, input logic [SW-1:0] h);
        exp_t e;
        e.tag  = tag;
        e.flap = f;
        e.rrst = r;
        e.st   = s;
        e.fin  = fn;
        e.hs   = h;
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One game tick, no closer than 8 clocks to the previous one.
    task automatic do_tick();
        exp_t e;
        idle(7);
        if (sb.size() == 0) begin
            n_total = n_total + 1;
            $error("FAIL scoreboard_empty observed=0 expected=1");
        end else begin
            e = sb.pop_front();
            @(negedge clk);
            game_tick = 1'b1;
            #1;
            chk({e.tag, ".flap"}, 32'(flap), 32'(e.flap));
            chk({e.tag, ".round_rst"}, 32'(round_rst), 32'(e.rrst));
            @(negedge clk);
            game_tick = 1'b0;
            #1;
            chk({e.tag, ".state"}, 32'(state), 32'(e.st));
            chk({e.tag, ".finished"}, 32'(finished), 32'(e.fin));
            chk({e.tag, ".high_score"}, 32'(high_score), 32'(e.hs));
            chk({e.tag, ".flap_off_tick"}, 32'(flap), 32'd0);
        end
    endtask

    // A clean press: held well past the debounce window, then released.
    task automatic press();
        btn_raw = 1'b1;
        idle(20);
        btn_raw = 1'b0;
        idle(20);
    endtask

    initial begin
        n_total    = 0;
        n_pass     = 0;
        reset_n    = 1'b0;
        game_tick  = 1'b0;
        btn_raw    = 1'b0;
        hit_column = 1'b0;
        score      = '0;
        idle(3);
        // While in reset, a tick must not produce pulses.
        game_tick = 1'b1;
        #1;
        chk("reset.state", 32'(state), 32'd0);
        chk("reset.finished", 32'(finished), 32'd0);
        chk("reset.flap", 32'(flap), 32'd0);
        chk("reset.round_rst", 32'(round_rst), 32'd0);
        chk("reset.high_score", 32'(high_score), 32'd0);
        @(negedge clk);
        game_tick = 1'b0;
        reset_n   = 1'b1;
        idle(2);

        // Three-clock glitch is rejected; hit_column is ignored in IDLE.
        btn_raw    = 1'b1;
        idle(3);
        btn_raw    = 1'b0;
        hit_column = 1'b1;
        idle(10);
        expect_tick("glitch", 1'b0, 1'b0, 2'd0, 1'b0, 10'd0);
        do_tick();
        hit_column = 1'b0;

        // Valid press in IDLE starts the round.
        press();
        expect_tick("start", 1'b1, 1'b1, 2'd1, 1'b0, 10'd0);
        do_tick();
        expect_tick("play_quiet", 1'b0, 1'b0, 2'd1, 1'b0, 10'd0);
        do_tick();

        // Two presses before one tick give one flap.
        press();
        press();
        expect_tick("double_press", 1'b1, 1'b0, 2'd1, 1'b0, 10'd0);
        do_tick();
        expect_tick("double_after", 1'b0, 1'b0, 2'd1, 1'b0, 10'd0);
        do_tick();

        // Hit beats a simultaneous press; score 7 becomes the best.
        press();
        hit_column = 1'b1;
        score      = 10'd7;
        expect_tick("hit", 1'b0, 1'b0, 2'd2, 1'b1, 10'd7);
        do_tick();

        // DEAD hold of three ticks; presses and hits are ignored.
        press();
        expect_tick("dead1", 1'b0, 1'b0, 2'd2, 1'b1, 10'd7);
        do_tick();
        expect_tick("dead2", 1'b0, 1'b0, 2'd2, 1'b1, 10'd7);
        do_tick();
        press();
        expect_tick("dead3", 1'b0, 1'b0, 2'd3, 1'b1, 10'd7);
        do_tick();
        hit_column = 1'b0;
        expect_tick("over_wait", 1'b0, 1'b0, 2'd3, 1'b1, 10'd7);
        do_tick();

        // Restart from OVER keeps the best score.
        press();
        expect_tick("restart", 1'b0, 1'b1, 2'd0, 1'b0, 10'd7);
        do_tick();

        // A lower score does not replace the best.
        press();
        expect_tick("round2", 1'b1, 1'b1, 2'd1, 1'b0, 10'd7);
        do_tick();
        hit_column = 1'b1;
        score      = 10'd5;
        expect_tick("die_low", 1'b0, 1'b0, 2'd2, 1'b1, 10'd7);
        do_tick();
        hit_column = 1'b0;
        expect_tick("r2_dead1", 1'b0, 1'b0, 2'd2, 1'b1, 10'd7);
        do_tick();
        expect_tick("r2_dead2", 1'b0, 1'b0, 2'd2, 1'b1, 10'd7);
        do_tick();
        expect_tick("r2_over", 1'b0, 1'b0, 2'd3, 1'b1, 10'd7);
        do_tick();
        press();
        expect_tick("r2_restart", 1'b0, 1'b1, 2'd0, 1'b0, 10'd7);
        do_tick();
        press();
        expect_tick("round3", 1'b1, 1'b1, 2'd1, 1'b0, 10'd7);
        do_tick();

        // Reset during PLAY with a press pending clears everything at once.
        press();
        reset_n   = 1'b0;
        game_tick = 1'b1;
        #1;
        chk("midreset.state", 32'(state), 32'd0);
        chk("midreset.flap", 32'(flap), 32'd0);
        chk("midreset.round_rst", 32'(round_rst), 32'd0);
        chk("midreset.finished", 32'(finished), 32'd0);
        chk("midreset.high_score", 32'(high_score), 32'd0);
        @(negedge clk);
        game_tick = 1'b0;
        idle(2);
        reset_n = 1'b1;
        expect_tick("post_reset", 1'b0, 1'b0, 2'd0, 1'b0, 10'd0);
        do_tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
